// File: rtl/fetch_regfile_core_pkg.sv
// fetch_regfile_core_pkg: shared constants and the IF/ID register layout for the fetch front end.
package fetch_regfile_core_pkg;
  localparam int XLEN = 32;
  localparam int REG_COUNT = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic valid;
  } if_id_t;
endpackage

// File: rtl/fetch_if_stage.sv
// fetch_if_stage: program counter and the IF/ID pipeline register.
module fetch_if_stage
  import fetch_regfile_core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = fetch_regfile_core_pkg::RESET_PC,
  parameter logic [31:0] NOP_INSTR = fetch_regfile_core_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        pc_src,
  input  logic [31:0] new_pc,
  input  logic [31:0] instr,
  output logic [31:0] pc,
  output logic        fetch,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instruction,
  output logic        if_id_valid
);
  localparam if_id_t BUBBLE = '{pc: '0, instr: NOP_INSTR, valid: 1'b0};
  if_id_t if_id;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      pc <= RESET_PC;
      if_id <= BUBBLE;
    end else begin
      pc <= pc_src ? new_pc : stall ? pc : pc + 32'd4;
      if_id <= flush ? BUBBLE : stall ? if_id : '{pc: pc, instr: instr, valid: 1'b1};
    end
  assign fetch = reset & ~stall;
  assign if_id_pc = if_id.pc;
  assign if_id_instruction = if_id.instr;
  assign if_id_valid = if_id.valid;
endmodule

// File: rtl/fetch_imem.sv
// fetch_imem: word-addressed instruction memory with a combinational fetch port and a debug load/read port.
module fetch_imem
  import fetch_regfile_core_pkg::*;
#(
  parameter int IMEM_DEPTH = 256,
  parameter logic [31:0] NOP_INSTR = fetch_regfile_core_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic [31:0] fetch_addr,
  output logic [31:0] fetch_data,
  input  logic        debug_en,
  input  logic [31:0] debug_addr,
  input  logic [31:0] debug_data_in,
  input  logic        debug_write_en,
  output logic [31:0] debug_data_out
);
  localparam int AW = $clog2(IMEM_DEPTH);
  logic [XLEN-1:0] mem [IMEM_DEPTH];
  logic [29:0] fetch_word, debug_word;
  logic fetch_ok, debug_ok, unused_byte_bits;
  assign fetch_word = fetch_addr[31:2];
  assign debug_word = debug_addr[31:2];
  assign fetch_ok = (fetch_word >> AW) == '0;
  assign debug_ok = (debug_word >> AW) == '0;
  assign unused_byte_bits = ^{fetch_addr[1:0], debug_addr[1:0]};
  // contents survive reset, so the write port is deliberately unreset
  always_ff @(posedge clk)
    if (debug_en && debug_write_en && debug_ok) mem[debug_word[AW-1:0]] <= debug_data_in;
  assign fetch_data = fetch_ok ? mem[fetch_word[AW-1:0]] : NOP_INSTR;
  assign debug_data_out = !debug_en ? '0 : debug_ok ? mem[debug_word[AW-1:0]] : NOP_INSTR;
endmodule

// File: rtl/fetch_regfile.sv
// fetch_regfile: 32x32 integer register file with write-through reads and a flat debug view.
module fetch_regfile
  import fetch_regfile_core_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic [4:0]                rs1_addr,
  input  logic [4:0]                rs2_addr,
  output logic [31:0]               rs1_data,
  output logic [31:0]               rs2_data,
  input  logic [4:0]                rd_addr,
  input  logic [31:0]               rd_data,
  input  logic                      reg_write,
  output logic [XLEN*REG_COUNT-1:0] debug_registers
);
  logic [XLEN-1:0] regs [REG_COUNT];
  logic wr;
  assign wr = reg_write && rd_addr != 5'd0;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      for (int k = 0; k < REG_COUNT; k++) regs[k] <= '0;
    end else if (wr) begin
      regs[rd_addr] <= rd_data;
    end
  assign rs1_data = rs1_addr == 5'd0 ? '0 : (wr && rd_addr == rs1_addr) ? rd_data : regs[rs1_addr];
  assign rs2_data = rs2_addr == 5'd0 ? '0 : (wr && rd_addr == rs2_addr) ? rd_data : regs[rs2_addr];
  for (genvar i = 0; i < REG_COUNT; i++) begin : g_dbg
    assign debug_registers[XLEN*i +: XLEN] = i == 0 ? '0 : regs[i];
  end
endmodule

// File: rtl/fetch_regfile_core.sv
// fetch_regfile_core: RV32I front end wiring the fetch stage, instruction memory and register file.
module fetch_regfile_core
  import fetch_regfile_core_pkg::*;
#(
  parameter int IMEM_DEPTH = 256,
  parameter logic [31:0] RESET_PC = fetch_regfile_core_pkg::RESET_PC,
  parameter logic [31:0] NOP_INSTR = fetch_regfile_core_pkg::NOP_INSTR
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          stall,
  input  logic          flush,
  input  logic          pc_src,
  input  logic [31:0]   new_pc,
  output logic [31:0]   imem_addr,
  output logic          imem_read,
  output logic [31:0]   if_id_pc,
  output logic [31:0]   if_id_instruction,
  output logic          if_id_valid,
  input  logic          debug_en,
  input  logic [31:0]   debug_addr,
  input  logic [31:0]   debug_data_in,
  input  logic          debug_write_en,
  output logic [31:0]   debug_data_out,
  input  logic [4:0]    rs1_addr,
  input  logic [4:0]    rs2_addr,
  output logic [31:0]   rs1_data,
  output logic [31:0]   rs2_data,
  input  logic [4:0]    rd_addr,
  input  logic [31:0]   rd_data,
  input  logic          reg_write,
  output logic [1023:0] debug_registers
);
  logic [31:0] fetched;
  fetch_if_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) u_if (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .pc_src(pc_src), .new_pc(new_pc),
    .instr(fetched), .pc(imem_addr), .fetch(imem_read), .if_id_pc(if_id_pc),
    .if_id_instruction(if_id_instruction), .if_id_valid(if_id_valid)
  );
  fetch_imem #(.IMEM_DEPTH(IMEM_DEPTH), .NOP_INSTR(NOP_INSTR)) u_imem (
    .clk(clk), .fetch_addr(imem_addr), .fetch_data(fetched), .debug_en(debug_en),
    .debug_addr(debug_addr), .debug_data_in(debug_data_in), .debug_write_en(debug_write_en),
    .debug_data_out(debug_data_out)
  );
  fetch_regfile u_rf (
    .clk(clk), .reset(reset), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data),
    .rs2_data(rs2_data), .rd_addr(rd_addr), .rd_data(rd_data), .reg_write(reg_write),
    .debug_registers(debug_registers)
  );
endmodule

// File: tb/tb_fetch_regfile_core.sv
// tb_fetch_regfile_core: directed stimulus feeding a scoreboard queue drained by an independent monitor.
module tb_fetch_regfile_core;
  localparam int S_ADDR = 0, S_PC = 1, S_INSTR = 2, S_VALID = 3, S_READ = 4, S_RS1 = 5, S_RS2 = 6,
                 S_DBG = 7, S_ANYREG = 200, S_SLICE = 100;
  typedef struct {
    string name;
    int sel;
    logic [31:0] val;
  } exp_t;
  exp_t sb[$];
  int checks = 0, fails = 0;
  logic clk = 0, reset = 0, stall = 0, flush = 0, pc_src = 0;
  logic [31:0] new_pc = 0, debug_addr = 0, debug_data_in = 0, rd_data = 0;
  logic debug_en = 0, debug_write_en = 0, reg_write = 0;
  logic [4:0] rs1_addr = 0, rs2_addr = 0, rd_addr = 0;
  logic [31:0] imem_addr, if_id_pc, if_id_instruction, debug_data_out, rs1_data, rs2_data;
  logic imem_read, if_id_valid;
  logic [1023:0] debug_registers;

  fetch_regfile_core dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .pc_src(pc_src), .new_pc(new_pc),
    .imem_addr(imem_addr), .imem_read(imem_read), .if_id_pc(if_id_pc),
    .if_id_instruction(if_id_instruction), .if_id_valid(if_id_valid), .debug_en(debug_en),
    .debug_addr(debug_addr), .debug_data_in(debug_data_in), .debug_write_en(debug_write_en),
    .debug_data_out(debug_data_out), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .rd_addr(rd_addr), .rd_data(rd_data),
    .reg_write(reg_write), .debug_registers(debug_registers)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] observe(int s);
    if (s == S_ADDR) return imem_addr;
    if (s == S_PC) return if_id_pc;
    if (s == S_INSTR) return if_id_instruction;
    if (s == S_VALID) return {31'd0, if_id_valid};
    if (s == S_READ) return {31'd0, imem_read};
    if (s == S_RS1) return rs1_data;
    if (s == S_RS2) return rs2_data;
    if (s == S_DBG) return debug_data_out;
    if (s == S_ANYREG) return {31'd0, |debug_registers};
    return debug_registers[(s - S_SLICE)*32 +: 32];
  endfunction

  // Monitor: samples mid low-phase, after inputs settle and before the next rising edge.
  initial forever begin
    @(negedge clk);
    #3;
    while (sb.size() > 0) begin
      exp_t e;
      logic [31:0] got;
      e = sb.pop_front();
      got = observe(e.sel);
      checks++;
      if (got !== e.val) begin
        fails++;
        $display("FAIL %s: got %h expected %h at %0t", e.name, got, e.val, $time);
      end
    end
  end

  task automatic expect_v(string n, int s, logic [31:0] v);
    sb.push_back('{n, s, v});
  endtask

  task automatic expect_ifid(string n, logic [31:0] addr, logic [31:0] pc, logic [31:0] ins, logic v);
    expect_v({n, "_addr"}, S_ADDR, addr);
    expect_v({n, "_pc"}, S_PC, pc);
    expect_v({n, "_instr"}, S_INSTR, ins);
    expect_v({n, "_valid"}, S_VALID, {31'd0, v});
  endtask

  task automatic dbg_write(logic [31:0] a, logic [31:0] d);
    @(negedge clk);
    debug_en = 1; debug_write_en = 1; debug_addr = a; debug_data_in = d;
  endtask

  initial begin
    logic [31:0] prog [4];
    prog[0] = 32'h0050_0093; prog[1] = 32'h00a0_0113; prog[2] = 32'h0020_81b3; prog[3] = 32'h0000_0013;
    // preload while reset holds the PC
    for (int i = 0; i < 4; i++) begin
      dbg_write(32'(i*4), prog[i]);
      if (i == 0) begin
        expect_ifid("rst", 32'h0, 32'h0, 32'h13, 0);
        expect_v("rst_read", S_READ, 0);
        expect_v("rst_regs", S_ANYREG, 0);
      end
    end
    @(negedge clk);
    reset = 1; debug_write_en = 0; debug_addr = 32'h4;
    expect_v("dbg_rd", S_DBG, prog[1]);
    expect_v("rel_read", S_READ, 1);
    expect_ifid("rel", 32'h0, 32'h0, 32'h13, 0);
    dbg_write(32'h40, 32'h1234_5678);
    expect_ifid("f0", 32'h4, 32'h0, prog[0], 1);
    @(negedge clk);
    debug_en = 0; debug_write_en = 0; stall = 1;
    expect_v("dbg_off", S_DBG, 0);
    expect_ifid("f1", 32'h8, 32'h4, prog[1], 1);
    expect_v("stall_read", S_READ, 0);
    @(negedge clk);
    expect_ifid("stall1", 32'h8, 32'h4, prog[1], 1);
    @(negedge clk);
    stall = 0;
    expect_ifid("stall2", 32'h8, 32'h4, prog[1], 1);
    expect_v("unstall_read", S_READ, 1);
    @(negedge clk);
    expect_ifid("f2", 32'hC, 32'h8, prog[2], 1);
    @(negedge clk);
    pc_src = 1; new_pc = 32'h40; flush = 1;
    expect_ifid("f3", 32'h10, 32'hC, prog[3], 1);
    @(negedge clk);
    pc_src = 0; flush = 0;
    expect_ifid("flush", 32'h40, 32'h0, 32'h13, 0);
    @(negedge clk);
    pc_src = 1; new_pc = 32'h400;
    expect_ifid("redir", 32'h44, 32'h40, 32'h1234_5678, 1);
    @(negedge clk);
    pc_src = 0;
    expect_v("oor_addr", S_ADDR, 32'h400);
    @(negedge clk);
    pc_src = 1; new_pc = 32'hFFFF_FFFC;
    expect_ifid("oor", 32'h404, 32'h400, 32'h13, 1);
    @(negedge clk);
    pc_src = 0;
    expect_v("top_addr", S_ADDR, 32'hFFFF_FFFC);
    @(negedge clk);
    reg_write = 1; rd_addr = 5; rd_data = 32'hDEAD_BEEF; rs1_addr = 5;
    expect_ifid("wrap", 32'h0, 32'hFFFF_FFFC, 32'h13, 1);
    expect_v("bypass_x5", S_RS1, 32'hDEAD_BEEF);
    expect_v("x5_prewrite", S_SLICE + 5, 0);
    @(negedge clk);
    rd_addr = 0; rd_data = 32'hFFFF_FFFF; rs2_addr = 0;
    expect_v("x5_read", S_RS1, 32'hDEAD_BEEF);
    expect_v("x5_slice", S_SLICE + 5, 32'hDEAD_BEEF);
    expect_v("x0_bypass", S_RS2, 0);
    @(negedge clk);
    rd_addr = 31; rd_data = 32'h0BAD_F00D; rs1_addr = 0; rs2_addr = 31;
    expect_v("x0_slice", S_SLICE + 0, 0);
    expect_v("x0_read", S_RS1, 0);
    expect_v("bypass_x31", S_RS2, 32'h0BAD_F00D);
    @(negedge clk);
    reg_write = 0; rd_addr = 5; rd_data = 32'h1111_1111; rs1_addr = 5;
    expect_v("x31_read", S_RS2, 32'h0BAD_F00D);
    expect_v("x31_slice", S_SLICE + 31, 32'h0BAD_F00D);
    expect_v("no_we_bypass", S_RS1, 32'hDEAD_BEEF);
    @(negedge clk);
    #1 reset = 0;
    expect_ifid("async_rst", 32'h0, 32'h0, 32'h13, 0);
    expect_v("async_regs", S_ANYREG, 0);
    expect_v("async_read", S_READ, 0);
    @(negedge clk);
    reset = 1; debug_en = 1; debug_addr = 32'h8;
    expect_v("mem_kept_dbg", S_DBG, prog[2]);
    @(negedge clk);
    expect_ifid("mem_kept", 32'h4, 32'h0, prog[0], 1);
    repeat (2) @(negedge clk);
    #5;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
